// File: rtl/rv32m_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32m_pkg
// Description : Shared encodings and constants for the RV32M sequential divider.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32m_pkg;

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
   localparam logic [31:0] INT_MIN   = 32'h8000_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage : rv32m_pkg
`default_nettype wire

// File: rtl/div_restore_step.sv
`default_nettype none
// ============================================================================
// Module      : div_restore_step
// Description : One restoring-division iteration: shift, trial subtract, select.
// Revision    : 1.0 - initial release
// ============================================================================
module div_restore_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rem,
   input  logic [XLEN-1:0] quo,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] rem_nxt,
   output logic [XLEN-1:0] quo_nxt
);

   logic [XLEN:0] w_shift;
   logic [XLEN:0] w_trial;
   logic          w_ge;

   // rem < divisor always holds, so the shifted value is below 2*divisor and
   // the sign of a 33-bit difference is a reliable borrow indicator.
   assign w_shift = {rem, quo[XLEN-1]};
   assign w_trial = w_shift - {1'b0, divisor};
   assign w_ge    = ~w_trial[XLEN];

   assign rem_nxt = w_ge ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];
   assign quo_nxt = {quo[XLEN-2:0], w_ge};

endmodule : div_restore_step
`default_nettype wire

// File: rtl/rv32m_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : rv32m_seq_divider
// Description : Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32m_seq_divider
   import rv32m_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [XLEN-1:0]   r_rem;
   logic [XLEN-1:0]   r_quo;
   logic [XLEN-1:0]   r_dvs;
   logic [XLEN-1:0]   r_result;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_q_neg;
   logic              r_r_neg;
   logic              r_sel_rem;

   logic              w_accept;
   logic              w_signed;
   logic              w_div0;
   logic              w_ovf;
   logic              w_special;
   logic [XLEN-1:0]   w_special_res;
   logic [XLEN-1:0]   w_dvd_abs;
   logic [XLEN-1:0]   w_dvs_abs;
   logic [XLEN-1:0]   w_step_rem;
   logic [XLEN-1:0]   w_step_quo;
   logic [XLEN-1:0]   w_fix_quo;
   logic [XLEN-1:0]   w_fix_rem;

   assign w_signed  = (op == OP_DIV) || (op == OP_REM);
   assign w_div0    = (divisor == '0);
   assign w_ovf     = w_signed && (dividend == INT_MIN) && (divisor == '1);
   assign w_special = w_div0 || w_ovf;
   assign w_accept  = (r_state == ST_IDLE) && in_valid && !flush;

   always_comb begin
      w_special_res = op[1] ? '0 : INT_MIN;
      if (w_div0) begin
         w_special_res = op[1] ? dividend : DIV0_QUOT;
      end
   end

   // INT_MIN negates to itself, which read unsigned is the correct 2^31 magnitude.
   assign w_dvd_abs = (w_signed && dividend[XLEN-1]) ? -dividend : dividend;
   assign w_dvs_abs = (w_signed && divisor[XLEN-1])  ? -divisor  : divisor;

   assign w_fix_quo = r_q_neg ? -r_quo : r_quo;
   assign w_fix_rem = r_r_neg ? -r_rem : r_rem;

   div_restore_step #(
      .XLEN    (XLEN)
   ) u_step (
      .rem     (r_rem),
      .quo     (r_quo),
      .divisor (r_dvs),
      .rem_nxt (w_step_rem),
      .quo_nxt (w_step_quo)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (in_valid) begin
               w_state_nxt = w_special ? ST_DONE : ST_CALC;
            end
         end
         ST_CALC: begin
            if (r_cnt == '0) begin
               w_state_nxt = ST_FIX;
            end
         end
         ST_FIX:  w_state_nxt = ST_DONE;
         ST_DONE: begin
            if (out_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      if (flush) begin
         w_state_nxt = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rem     <= '0;
         r_quo     <= '0;
         r_dvs     <= '0;
         r_result  <= '0;
         r_cnt     <= '0;
         r_q_neg   <= 1'b0;
         r_r_neg   <= 1'b0;
         r_sel_rem <= 1'b0;
      end else if (w_accept) begin
         r_sel_rem <= op[1];
         if (w_special) begin
            r_result <= w_special_res;
         end else begin
            r_rem   <= '0;
            r_quo   <= w_dvd_abs;
            r_dvs   <= w_dvs_abs;
            r_cnt   <= '1;
            r_q_neg <= w_signed && (dividend[XLEN-1] ^ divisor[XLEN-1]);
            r_r_neg <= w_signed && dividend[XLEN-1];
         end
      end else if (r_state == ST_CALC) begin
         r_rem <= w_step_rem;
         r_quo <= w_step_quo;
         r_cnt <= r_cnt - 1'b1;
      end else if (r_state == ST_FIX) begin
         r_result <= r_sel_rem ? w_fix_rem : w_fix_quo;
      end
   end

   assign in_ready  = (r_state == ST_IDLE);
   assign busy      = (r_state != ST_IDLE);
   assign out_valid = (r_state == ST_DONE);
   assign result    = r_result;

endmodule : rv32m_seq_divider
`default_nettype wire

// File: tb/tb_rv32m_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32m_seq_divider
// Description : Self-checking bench for rv32m_seq_divider against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32m_seq_divider;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  op;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        busy;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   rv32m_seq_divider dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .dividend  (dividend),
      .divisor   (divisor),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Architectural RV32M results, straight from the ISA rules.
   function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
      if (o[0]) return o[1] ? (a % b) : (a / b);
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return o[1] ? r[31:0] : q[31:0];
   endfunction

   function automatic int ref_latency(input logic [1:0] o, input logic [31:0] a,
                                      input logic [31:0] b);
      if (b == 32'd0) return 1;
      if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 34;
   endfunction

   // Called between clock edges with the DUT idle; returns between edges.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
      int   lat;
      logic seen;
      check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      op       = o;
      dividend = a;
      divisor  = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      op       = 2'($urandom);
      dividend = $urandom;
      divisor  = $urandom;
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 50) begin
         @(negedge clk);
         lat++;
         if (out_valid) seen = 1'b1;
      end
      check({tag, ".latency"}, seen ? 32'(lat) : 32'd0, 32'(ref_latency(o, a, b)));
      check({tag, ".result"}, result, ref_result(o, a, b));
      if (!seen) begin
         flush = 1'b1;
         @(posedge clk);
         #1;
         flush = 1'b0;
         @(negedge clk);
      end else if (out_ready) begin
         @(posedge clk);
         @(negedge clk);
         check({tag, ".handoff"}, {30'd0, out_valid, in_ready}, 32'd1);
      end
   endtask

   initial begin
      int   hits;
      logic [1:0]  ro;
      logic [31:0] ra, rb;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      op        = 2'b00;
      dividend  = 32'd0;
      divisor   = 32'd0;
      flush     = 1'b0;
      out_ready = 1'b1;
      #12;
      check("reset.busy", {31'd0, busy}, 32'd0);
      check("reset.in_ready", {31'd0, in_ready}, 32'd1);
      check("reset.out_valid", {31'd0, out_valid}, 32'd0);
      check("reset.result", result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(2'b01, 32'd100, 32'd7, "divu_100_7");
      run_op(2'b11, 32'd100, 32'd7, "remu_100_7");
      run_op(2'b00, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
      run_op(2'b10, 32'd7, 32'hFFFF_FFFE, "rem_7_m2");
      run_op(2'b00, 32'h8000_0000, 32'd2, "div_intmin_2");
      run_op(2'b01, 32'd5, 32'd0, "divu_5_0");
      run_op(2'b10, 32'h8000_0000, 32'd0, "rem_intmin_0");
      run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");

      // Backpressure: result parked in DONE until the consumer takes it.
      out_ready = 1'b0;
      run_op(2'b01, 32'd100, 32'd7, "bp");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp.hold", {result[31:3], out_valid, busy, in_ready}, {29'd1, 3'b110});
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp.release", {30'd0, out_valid, in_ready}, 32'd1);
      run_op(2'b00, 32'd1000, 32'hFFFF_FFFD, "bp.next");

      // Flush with the iteration counter at 20.
      in_valid = 1'b1;
      op       = 2'b01;
      dividend = 32'd12345;
      divisor  = 32'd17;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int i = 0; i < 11; i++) @(negedge clk);
      check("flush.busy_before", {31'd0, busy}, 32'd1);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("flush.state", {29'd0, busy, in_ready, out_valid}, 32'b010);
      hits = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) hits++;
      end
      check("flush.no_valid", 32'(hits), 32'd0);

      // Asynchronous reset in the middle of CALC.
      in_valid = 1'b1;
      op       = 2'b00;
      dividend = 32'd999;
      divisor  = 32'd4;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int i = 0; i < 10; i++) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("areset.state", {29'd0, busy, in_ready, out_valid}, 32'b010);
      check("areset.result", result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_op(2'b01, 32'd9, 32'd3, "after_reset");

      for (int n = 0; n < 60; n++) begin
         ro = 2'($urandom);
         ra = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = $urandom;
            1:       rb = 32'd0;
            2:       rb = 32'($urandom_range(1, 50)) * (($urandom & 1) != 0 ? -1 : 1);
            default: begin
               ra = 32'h8000_0000;
               rb = ($urandom & 1) != 0 ? 32'hFFFF_FFFF : $urandom;
            end
         endcase
         run_op(ro, ra, rb, "random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_rv32m_seq_divider
`default_nettype wire
